dht11_read_scheduler: RTL

Sequences and shares the DHT11 transaction engine between NUM_REQ requesters and a periodic auto-poll.
- Enforces the sensor's minimum inter-read gap.
- Guards each read with a timeout watchdog and retries failed reads (checksum error or timeout).
- Coalesces concurrent requests into one sensor read.
- Holds the last good humidity/temperature sample for the SoC bus and display.

---
 rtl/dht11_read_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: shares one transaction engine between NUM_REQ requesters and an auto-poll, with inter-read gap, timeout watchdog and retry.
// Latency: req->eng_start 3 cycles once the gap is met, eng_done->ack 1 cycle; requests are never backpressured, they coalesce in the pending mask.
module dht11_read_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int MIN_GAP     = 100000000,
    parameter int TIMEOUT     = 1500000,
    parameter int MAX_RETRY   = 3,
    parameter int AUTO_PERIOD = 250000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               ack_fail,
    input  logic               auto_en,
    output logic               eng_start,
    output logic               eng_abort,
    input  logic               eng_done,
    input  logic               eng_err,
    input  logic [7:0]         eng_humidity,
    input  logic [7:0]         eng_temperature,
    output logic [7:0]         humidity,
    output logic [7:0]         temperature,
    output logic               sample_valid,
    output logic               stale,
    output logic [7:0]         err_count,
    output logic               busy
);

    localparam int GAP_W   = $clog2(MIN_GAP + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int AUTO_W  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(MIN_GAP);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [AUTO_W-1:0]  AUTO_LAST  = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    typedef struct packed {
        logic [7:0] humidity;
        logic [7:0] temperature;
    } sample_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [NUM_REQ-1:0]   serve_mask_q, serve_mask_d;
    logic                 auto_pending_q, auto_pending_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [AUTO_W-1:0]    auto_cnt_q, auto_cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 fail_q, fail_d;
    sample_t              sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 stale_q, stale_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 auto_tick;
    logic                 attempt_fail;
    logic [NUM_REQ-1:0]   clr_mask;

    always_comb begin
        state_d        = state_q;
        serve_mask_d   = serve_mask_q;
        retry_cnt_d    = retry_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        fail_d         = fail_q;
        sample_d       = sample_q;
        sample_valid_d = sample_valid_q;
        stale_d        = stale_q;
        err_count_d    = err_count_q;
        auto_cnt_d     = auto_cnt_q;
        auto_tick      = 1'b0;
        attempt_fail   = 1'b0;
        clr_mask       = '0;
        eng_start      = 1'b0;
        eng_abort      = 1'b0;
        ack            = '0;
        ack_fail       = 1'b0;

        if (auto_en) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_cnt_d = '0;
                auto_tick  = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + 1'b1;
            end
        end else begin
            auto_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if ((pending_q != '0) || auto_pending_q) begin
                    serve_mask_d = pending_q;
                    retry_cnt_d  = '0;
                    state_d      = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_MAX) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start  = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A completion in the final watchdog cycle is honoured, not aborted.
                if (eng_done) begin
                    if (!eng_err) begin
                        sample_d.humidity    = eng_humidity;
                        sample_d.temperature = eng_temperature;
                        sample_valid_d       = 1'b1;
                        stale_d              = 1'b0;
                        fail_d               = 1'b0;
                        state_d              = S_REPORT;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    eng_abort    = 1'b1;
                    attempt_fail = 1'b1;
                end

                if (attempt_fail) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    if (retry_cnt_q < RETRY_LAST) begin
                        state_d = S_GAP;
                    end else begin
                        stale_d = 1'b1;
                        fail_d  = 1'b1;
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                ack      = serve_mask_q;
                ack_fail = fail_q;
                clr_mask = serve_mask_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // New requests win over the acknowledge clear so a same-cycle re-request is kept.
        pending_d      = (pending_q & ~clr_mask) | req;
        auto_pending_d = (auto_pending_q & ~eng_start) | auto_tick;

        if (eng_done || eng_abort) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_MAX) begin
            gap_cnt_d = gap_cnt_q;
        end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            serve_mask_q   <= '0;
            auto_pending_q <= 1'b0;
            gap_cnt_q      <= '0;
            auto_cnt_q     <= '0;
            retry_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            fail_q         <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            stale_q        <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            serve_mask_q   <= serve_mask_d;
            auto_pending_q <= auto_pending_d;
            gap_cnt_q      <= gap_cnt_d;
            auto_cnt_q     <= auto_cnt_d;
            retry_cnt_q    <= retry_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            fail_q         <= fail_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            stale_q        <= stale_d;
            err_count_q    <= err_count_d;
        end
    end

    assign humidity     = sample_q.humidity;
    assign temperature  = sample_q.temperature;
    assign sample_valid = sample_valid_q;
    assign stale        = stale_q;
    assign err_count    = err_count_q;
    assign busy         = (state_q != S_IDLE);

endmodule
